// File: rtl/axis_data_checker_pkg.sv
// Shared constants, state encoding and helpers for the AXI-Stream pattern checker.
package axis_data_checker_pkg;

    localparam int          BEAT_BYTES   = 64;
    localparam logic [31:0] PATTERN_FILL = 32'hDEADBEEF;

    localparam int ERR_DATA         = 0;
    localparam int ERR_KEEP         = 1;
    localparam int ERR_EARLY_LAST   = 2;
    localparam int ERR_MISSING_LAST = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    function automatic logic [63:0] keep_from_count(input logic [31:0] n);
        if (n >= 32'd64) return '1;
        return (64'd1 << n) - 64'd1;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/axis_data_pattern_cmp.sv
// Stage 1: compares one beat against the generator pattern for its offset and
// registers the data/keep mismatch bits.
module axis_data_pattern_cmp
    import axis_data_checker_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [BEAT_BYTES*8-1:0]   tdata,
    input  logic [BEAT_BYTES-1:0]     tkeep,
    input  logic [31:0]               off,
    input  logic [31:0]               len,
    output logic                      data_err,
    output logic                      keep_err
);

    logic [32:0]             end_off;
    logic                    is_last;
    logic [31:0]             remain;
    logic [BEAT_BYTES-1:0]   exp_keep;
    logic [BEAT_BYTES*8-1:0] exp_data;
    logic [BEAT_BYTES-1:0]   byte_mism;

    assign end_off  = {1'b0, off} + 33'd64;
    assign is_last  = end_off >= {1'b0, len};
    assign remain   = len - off;
    assign exp_keep = is_last ? keep_from_count(remain) : '1;
    assign exp_data = {{14{PATTERN_FILL}}, ~off, off};

    always_comb begin
        byte_mism = '0;
        for (int i = 0; i < BEAT_BYTES; i++)
            byte_mism[i] = exp_keep[i] && (tdata[8*i +: 8] != exp_data[8*i +: 8]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_err <= 1'b0;
            keep_err <= 1'b0;
        end else begin
            data_err <= en && (|byte_mism);
            keep_err <= en && (tkeep != exp_keep);
        end
    end

endmodule

// File: rtl/axis_data_checker.sv
// Frame checker for the test-pattern stream: FSM, tready throttle, stage-2 flag
// accumulation and saturating statistics counters.
module axis_data_checker
    import axis_data_checker_pkg::*;
#(
    parameter int DATA_WIDTH = 512
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tuser,
    input  logic [31:0]             length,
    input  logic [7:0]              ready_pattern,
    input  logic                    clear,
    output logic                    frame_done,
    output logic [3:0]              frame_err_flags,
    output logic                    frame_aborted,
    output logic [31:0]             frames_ok_cnt,
    output logic [31:0]             frames_err_cnt,
    output logic [31:0]             frames_abort_cnt,
    output logic [63:0]             bytes_rx_cnt,
    output logic [31:0]             first_err_offset
);

    state_t      state;
    logic [2:0]  ptr;
    logic [31:0] off_q, len_q;

    logic        hs, first_beat, checking, len_zero, cur_is_last;
    logic        beat_early, beat_missing;
    logic [31:0] cur_off, cur_len;
    logic [32:0] cur_end;
    logic [6:0]  beat_bytes;

    assign s_axis_tready = ready_pattern[ptr] && !rst;
    assign hs            = s_axis_tvalid && s_axis_tready;
    assign first_beat    = (state == ST_IDLE);
    assign cur_len       = first_beat ? length : len_q;
    assign cur_off       = first_beat ? 32'd0 : off_q;
    assign cur_end       = {1'b0, cur_off} + 33'd64;
    assign cur_is_last   = cur_end >= {1'b0, cur_len};
    assign len_zero      = (cur_len == 32'd0);
    assign checking      = hs && (state != ST_DROP) && !len_zero;
    // A zero-length frame is wrong whatever tlast says, so both flags are raised.
    assign beat_early    = hs && (state != ST_DROP) && (len_zero || (s_axis_tlast && !cur_is_last));
    assign beat_missing  = hs && (state != ST_DROP) && (len_zero || (!s_axis_tlast && cur_is_last));

    always_comb begin
        beat_bytes = '0;
        for (int i = 0; i < DATA_WIDTH/8; i++)
            beat_bytes = beat_bytes + 7'(s_axis_tkeep[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            ptr   <= '0;
            off_q <= '0;
            len_q <= '0;
        end else begin
            ptr <= ptr + 3'd1;
            if (hs) begin
                if (first_beat) len_q <= length;
                off_q <= cur_off + 32'd64;
                if (s_axis_tlast)
                    state <= ST_IDLE;
                else if (state == ST_DROP || beat_missing)
                    state <= ST_DROP;
                else
                    state <= ST_RUN;
            end
        end
    end

    logic        s1_valid, s1_last, s1_first, s1_early, s1_missing, s1_user;
    logic        s1_data_err, s1_keep_err;
    logic [31:0] s1_off;
    logic [6:0]  s1_bytes;

    axis_data_pattern_cmp u_cmp (
        .clk      (clk),
        .rst      (rst),
        .en       (checking),
        .tdata    (s_axis_tdata),
        .tkeep    (s_axis_tkeep),
        .off      (cur_off),
        .len      (cur_len),
        .data_err (s1_data_err),
        .keep_err (s1_keep_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_last    <= 1'b0;
            s1_first   <= 1'b0;
            s1_early   <= 1'b0;
            s1_missing <= 1'b0;
            s1_user    <= 1'b0;
            s1_off     <= '0;
            s1_bytes   <= '0;
        end else begin
            s1_valid   <= hs;
            s1_last    <= hs && s_axis_tlast;
            s1_first   <= hs && first_beat;
            s1_early   <= beat_early;
            s1_missing <= beat_missing;
            s1_user    <= hs && s_axis_tuser;
            s1_off     <= cur_off;
            s1_bytes   <= beat_bytes;
        end
    end

    logic [3:0]  acc_flags, beat_flags, flags_now;
    logic        acc_abort, abort_now;
    logic [64:0] bytes_sum;

    assign beat_flags[ERR_DATA]         = s1_data_err;
    assign beat_flags[ERR_KEEP]         = s1_keep_err;
    assign beat_flags[ERR_EARLY_LAST]   = s1_early;
    assign beat_flags[ERR_MISSING_LAST] = s1_missing;
    assign flags_now = (s1_first ? 4'd0 : acc_flags) | beat_flags;
    assign abort_now = (s1_first ? 1'b0 : acc_abort) | s1_user;
    assign bytes_sum = {1'b0, bytes_rx_cnt} + 65'(s1_bytes);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_flags        <= '0;
            acc_abort        <= 1'b0;
            frame_done       <= 1'b0;
            frame_err_flags  <= '0;
            frame_aborted    <= 1'b0;
            frames_ok_cnt    <= '0;
            frames_err_cnt   <= '0;
            frames_abort_cnt <= '0;
            bytes_rx_cnt     <= '0;
            first_err_offset <= '1;
        end else begin
            frame_done <= s1_valid && s1_last;
            if (s1_valid) begin
                acc_flags <= flags_now;
                acc_abort <= abort_now;
            end
            if (s1_valid && s1_last) begin
                frame_err_flags <= flags_now;
                frame_aborted   <= abort_now;
            end
            if (clear) begin
                frames_ok_cnt    <= '0;
                frames_err_cnt   <= '0;
                frames_abort_cnt <= '0;
                bytes_rx_cnt     <= '0;
                first_err_offset <= '1;
            end else if (s1_valid) begin
                bytes_rx_cnt <= bytes_sum[64] ? '1 : bytes_sum[63:0];
                if ((|beat_flags) && first_err_offset == '1)
                    first_err_offset <= s1_off;
                if (s1_last) begin
                    if (abort_now)
                        frames_abort_cnt <= sat_inc(frames_abort_cnt);
                    else if (|flags_now)
                        frames_err_cnt <= sat_inc(frames_err_cnt);
                    else
                        frames_ok_cnt <= sat_inc(frames_ok_cnt);
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_data_checker.sv
// Directed bench: driver pushes hand-computed frame results into a queue, a
// negedge monitor pops and compares them whenever frame_done pulses.
module tb_axis_data_checker;

    logic         clk = 1'b0;
    logic         rst;
    logic [511:0] s_axis_tdata;
    logic [63:0]  s_axis_tkeep;
    logic         s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
    logic [31:0]  length;
    logic [7:0]   ready_pattern;
    logic         clear;
    logic         frame_done;
    logic [3:0]   frame_err_flags;
    logic         frame_aborted;
    logic [31:0]  frames_ok_cnt, frames_err_cnt, frames_abort_cnt, first_err_offset;
    logic [63:0]  bytes_rx_cnt;

    always #5 clk = ~clk;

    axis_data_checker dut (
        .clk              (clk),
        .rst              (rst),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tkeep     (s_axis_tkeep),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tready    (s_axis_tready),
        .s_axis_tlast     (s_axis_tlast),
        .s_axis_tuser     (s_axis_tuser),
        .length           (length),
        .ready_pattern    (ready_pattern),
        .clear            (clear),
        .frame_done       (frame_done),
        .frame_err_flags  (frame_err_flags),
        .frame_aborted    (frame_aborted),
        .frames_ok_cnt    (frames_ok_cnt),
        .frames_err_cnt   (frames_err_cnt),
        .frames_abort_cnt (frames_abort_cnt),
        .bytes_rx_cnt     (bytes_rx_cnt),
        .first_err_offset (first_err_offset)
    );

    int checks = 0;
    int passed = 0;
    int cyc    = 0;
    int last_hs = 0;
    logic [2:0] m_ptr;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (rst) m_ptr <= '0; else m_ptr <= m_ptr + 3'd1;

    typedef struct {
        logic [3:0]  flags;
        logic        ab;
        logic [31:0] ok, err, abrt;
        logic [63:0] bytes;
        logic [31:0] first;
        int          due;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (!rst && frame_done) begin
            if (q.size() == 0) begin
                checks++;
                $display("FAIL spurious_frame_done: got 1 expected 0 (t=%0t)", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("done_latency", 64'(cyc), 64'(e.due));
                chk("err_flags", 64'(frame_err_flags), 64'(e.flags));
                chk("aborted", 64'(frame_aborted), 64'(e.ab));
                chk("ok_cnt", 64'(frames_ok_cnt), 64'(e.ok));
                chk("err_cnt", 64'(frames_err_cnt), 64'(e.err));
                chk("abort_cnt", 64'(frames_abort_cnt), 64'(e.abrt));
                chk("bytes_cnt", bytes_rx_cnt, e.bytes);
                chk("first_err_off", 64'(first_err_offset), 64'(e.first));
            end
        end
    end

    task automatic expect_frame(input logic [3:0] flags, input logic ab, input int ok, input int err,
                                input int abrt, input longint bytes, input logic [31:0] first);
        exp_t e;
        e.flags = flags; e.ab = ab; e.ok = 32'(ok); e.err = 32'(err); e.abrt = 32'(abrt);
        e.bytes = 64'(bytes); e.first = first; e.due = last_hs + 2;
        q.push_back(e);
    endtask

    function automatic logic [511:0] pat(input logic [31:0] off);
        return {{14{32'hDEADBEEF}}, ~off, off};
    endfunction

    function automatic logic [63:0] keep_n(input int n);
        if (n >= 64) return '1;
        return (64'd1 << n) - 64'd1;
    endfunction

    task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input logic l, input logic u);
        int n;
        n = 0;
        s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l; s_axis_tuser = u;
        s_axis_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_axis_tready) begin
                last_hs = cyc;
                @(posedge clk); #1;
                break;
            end
            n++;
            if (n > 64) begin
                checks++;
                $display("FAIL handshake_timeout: got tready=0 for 64 cycles expected handshake");
                @(posedge clk); #1;
                break;
            end
        end
    endtask

    task automatic send_frame(input int len, input int nbeats, input int last_at, input int flip_beat,
                              input int flip_bit, input int badkeep_beat, input int user_beat);
        logic [511:0] d;
        logic [63:0]  k;
        int           o;
        length = 32'(len);
        for (int b = 0; b < nbeats; b++) begin
            o = b * 64;
            d = pat(32'(o));
            if (o + 64 >= len && len > o) k = keep_n(len - o);
            else                          k = '1;
            if (b == flip_beat)    d[flip_bit] = ~d[flip_bit];
            if (b == badkeep_beat) k = '1;
            send_beat(d, k, b == last_at, b == user_beat);
        end
    endtask

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    localparam logic [31:0] NONE = 32'hFFFF_FFFF;

    initial begin
        rst = 1'b1; clear = 1'b0; length = '0; ready_pattern = 8'hFF;
        s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tready", 64'(s_axis_tready), 64'd0);
        chk("rst_done", 64'(frame_done), 64'd0);
        chk("rst_ok_cnt", 64'(frames_ok_cnt), 64'd0);
        chk("rst_bytes", bytes_rx_cnt, 64'd0);
        chk("rst_first_err", 64'(first_err_offset), 64'(NONE));
        chk("rst_flags", 64'(frame_err_flags), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Clean 4-beat frame, then a single-beat frame back to back
        send_frame(256, 4, 3, -1, 0, -1, -1);
        expect_frame(4'h0, 1'b0, 1, 0, 0, 256, NONE);
        send_frame(64, 1, 0, -1, 0, -1, -1);
        expect_frame(4'h0, 1'b0, 2, 0, 0, 320, NONE);
        idle(4);
        pulse_clear();
        @(negedge clk);
        chk("clear_ok_cnt", 64'(frames_ok_cnt), 64'd0);
        chk("clear_bytes", bytes_rx_cnt, 64'd0);
        @(posedge clk); #1;

        // Partial last beat: correct keep, then all-ones keep
        send_frame(100, 2, 1, -1, 0, -1, -1);
        expect_frame(4'h0, 1'b0, 1, 0, 0, 100, NONE);
        send_frame(100, 2, 1, -1, 0, 1, -1);
        expect_frame(4'h2, 1'b0, 1, 1, 0, 228, 32'd64);
        idle(4);

        // Data corruption on beat 2, then early tlast on beat 1
        pulse_clear();
        send_frame(256, 4, 3, 2, 40, -1, -1);
        expect_frame(4'h1, 1'b0, 0, 1, 0, 256, 32'd128);
        send_frame(256, 2, 1, -1, 0, -1, -1);
        expect_frame(4'h4, 1'b0, 0, 2, 0, 384, 32'd128);
        idle(4);

        // Missing tlast: beats 2-3 discarded, one close
        pulse_clear();
        send_frame(128, 4, 3, -1, 0, -1, -1);
        expect_frame(4'h8, 1'b0, 0, 1, 0, 256, 32'd64);
        idle(4);

        // tuser abort
        pulse_clear();
        send_frame(192, 3, 2, -1, 0, -1, 1);
        expect_frame(4'h0, 1'b1, 0, 0, 1, 192, NONE);
        idle(4);

        // Throttled tready, two back-to-back frames, then reset mid-frame
        pulse_clear();
        ready_pattern = 8'b1010_0101;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("tready_pattern", 64'(s_axis_tready), 64'(ready_pattern[m_ptr]));
        end
        @(posedge clk); #1;
        send_frame(512, 8, 7, -1, 0, -1, -1);
        expect_frame(4'h0, 1'b0, 1, 0, 0, 512, NONE);
        send_frame(512, 8, 7, -1, 0, -1, -1);
        expect_frame(4'h0, 1'b0, 2, 0, 0, 1024, NONE);
        send_frame(512, 2, -1, -1, 0, -1, -1);
        idle(4);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_ok_cnt", 64'(frames_ok_cnt), 64'd0);
        chk("midrst_bytes", bytes_rx_cnt, 64'd0);
        chk("midrst_tready", 64'(s_axis_tready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        ready_pattern = 8'hFF;
        send_frame(64, 1, 0, -1, 0, -1, -1);
        expect_frame(4'h0, 1'b0, 1, 0, 0, 64, NONE);
        idle(6);

        chk("frames_outstanding", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
